// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV32I datapath: fetch/decode/execute/mem/writeback
// handshakes, halt detection, memory-wait timeout and a retired-instruction counter.
`timescale 1ns/1ps

module cpu_sequencer #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_load,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_wenb,
   output logic             pc_write,
   output logic             pc_sel,
   output logic             halted,
   output logic             error,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam int unsigned      TMO_W    = 16;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_HALT    = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_JUMP, C_BRANCH, C_LOAD, C_STORE, C_SYSTEM, C_ILLEGAL
   } iclass_t;

   state_t            state_q, state_d;
   iclass_t           cls_q, dec_cls;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              error_q, error_d;
   logic              halted_q;
   logic [CNT_W-1:0]  instret_q;
   logic              retire_c;

   function automatic iclass_t classify(input logic [6:0] op);
      case (op)
         7'b0000011: return C_LOAD;
         7'b0100011: return C_STORE;
         7'b1100011: return C_BRANCH;
         7'b1101111,
         7'b1100111: return C_JUMP;
         7'b0110111,
         7'b0010111,
         7'b0110011,
         7'b0010011: return C_ALU;
         7'b1110011: return C_SYSTEM;
         default:    return C_ILLEGAL;
      endcase
   endfunction

   assign dec_cls = classify(opcode);

   // State, captured instruction class, timeout, status and retire counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cls_q     <= C_ALU;
         tmo_q     <= '0;
         error_q   <= 1'b0;
         halted_q  <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         error_q  <= error_d;
         halted_q <= (state_d == S_HALT);
         if (state_q == S_DECODE) cls_q <= dec_cls;
         if (retire_c) instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Next state; a ready in the cycle the wait count expires still completes the access
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      error_d = error_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_DECODE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_HALT;
               error_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_DECODE: begin
            case (dec_cls)
               C_SYSTEM:  state_d = S_HALT;
               C_ILLEGAL: begin
                  state_d = S_HALT;
                  error_d = 1'b1;
               end
               default:   state_d = S_EXECUTE;
            endcase
         end
         S_EXECUTE: begin
            case (cls_q)
               C_BRANCH:        state_d = S_FETCH;
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ready) begin
               state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_HALT;
               error_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) tmo_d = '0;
   end

   // Strobes decode from state and same-cycle ready; reset suppresses any completing strobe
   always_comb begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_wenb = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      retire_c = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ready && !reset;
         end
         S_EXECUTE: begin
            if (cls_q == C_BRANCH) begin
               pc_write = !reset;
               pc_sel   = branch_taken;
               retire_c = 1'b1;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == C_STORE);
            if (dmem_ready && (cls_q == C_STORE)) begin
               pc_write = !reset;
               retire_c = 1'b1;
            end
         end
         S_WB: begin
            reg_wenb = !reset;
            pc_write = !reset;
            pc_sel   = (cls_q == C_JUMP);
            retire_c = 1'b1;
         end
         default: ;
      endcase
   end

   assign halted  = halted_q;
   assign error   = error_q;
   assign state   = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: randomized instruction stream with random ready delays,
// plus reset-in-flight and timeout scenarios on a second instance with a short timeout.
`timescale 1ns/1ps

module tb_cpu_sequencer;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct {
      bit          halt;
      bit          err;
      bit          pc_sel;
      bit          wen;
      bit          mem;
      bit          we;
      int          cyc;
      logic [31:0] instret;
   } exp_t;

   logic        clk, reset, start, branch_taken, imem_ready, dmem_ready;
   logic [6:0]  opcode;
   logic        imem_req, ir_load, dmem_req, dmem_we, reg_wenb, pc_write, pc_sel, halted, error;
   logic [2:0]  state;
   logic [31:0] instret;

   logic        reset2, start2, branch_taken2, imem_ready2, dmem_ready2;
   logic [6:0]  opcode2;
   logic        imem_req2, ir_load2, dmem_req2, dmem_we2, reg_wenb2, pc_write2, pc_sel2, halted2, error2;
   logic [2:0]  state2;
   logic [31:0] instret2;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        exp_q[$];
   logic [31:0] model_instret = 0;

   cpu_sequencer #(.CNT_W(32), .MEM_TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_wenb(reg_wenb), .pc_write(pc_write),
      .pc_sel(pc_sel), .halted(halted), .error(error), .state(state), .instret(instret)
   );

   cpu_sequencer #(.CNT_W(32), .MEM_TIMEOUT(4)) dut2 (
      .clk(clk), .reset(reset2), .start(start2), .opcode(opcode2), .branch_taken(branch_taken2),
      .imem_ready(imem_ready2), .dmem_ready(dmem_ready2), .imem_req(imem_req2), .ir_load(ir_load2),
      .dmem_req(dmem_req2), .dmem_we(dmem_we2), .reg_wenb(reg_wenb2), .pc_write(pc_write2),
      .pc_sel(pc_sel2), .halted(halted2), .error(error2), .state(state2), .instret(instret2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the expected outcome whenever an instruction completes or the DUT halts
   initial begin : monitor
      exp_t        e;
      bit          active;
      bit          mem_seen;
      bit          we_val;
      bit          inst_pend;
      int          cyc;
      int          n_ir;
      logic [31:0] inst_exp;
      active = 0; mem_seen = 0; we_val = 0; inst_pend = 0; cyc = 0; n_ir = 0; inst_exp = 0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            active    = 0;
            inst_pend = 0;
         end else begin
            if (inst_pend) begin
               check("instret_after_retire", instret, inst_exp);
               inst_pend = 0;
            end
            if (!active && imem_req) begin
               active = 1; cyc = 0; n_ir = 0; mem_seen = 0; we_val = 0;
            end
            if (active) begin
               cyc++;
               if (ir_load) n_ir++;
               if (dmem_req) begin
                  mem_seen = 1;
                  we_val   = dmem_we;
               end
               if (reg_wenb) check("reg_wenb_with_pc_write", pc_write, 1);
               if (pc_write || halted) begin
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_event: pc_write=%0b halted=%0b with no pending instruction",
                              pc_write, halted);
                  end else begin
                     e = exp_q.pop_front();
                     check("halted", halted, e.halt);
                     check("ir_load_count", n_ir, 1);
                     if (e.halt) begin
                        check("error_at_halt", error, e.err);
                        check("instret_at_halt", instret, e.instret);
                     end else begin
                        check("pc_sel", pc_sel, e.pc_sel);
                        check("reg_wenb", reg_wenb, e.wen);
                        check("latency", cyc, e.cyc);
                        check("mem_access", mem_seen, e.mem);
                        if (e.mem) check("dmem_we", we_val, e.we);
                        inst_pend = 1;
                        inst_exp  = e.instret;
                     end
                  end
                  active = 0;
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1; start = 0; imem_ready = 0; dmem_ready = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      model_instret = 0;
   endtask

   task automatic start_run();
      @(negedge clk);
      start = 1;
   endtask

   // Issue one instruction: push its expected outcome, then act as both memories until it ends
   task automatic run_instr(input logic [6:0] op, input int wi, input int wd, input bit bt);
      exp_t e;
      int   wic;
      int   wdc;
      int   guard;
      bit   done;
      wic = wi; wdc = wd; guard = 0; done = 0;
      e.halt = 0; e.err = 0; e.pc_sel = 0; e.wen = 0; e.mem = 0; e.we = 0; e.cyc = 0;
      case (op)
         OPC_LOAD:   begin e.mem = 1; e.wen = 1; e.cyc = 5 + wi + wd; end
         OPC_STORE:  begin e.mem = 1; e.we = 1; e.cyc = 4 + wi + wd; end
         OPC_BRANCH: begin e.pc_sel = bt; e.cyc = 3 + wi; end
         OPC_JAL, OPC_JALR: begin e.wen = 1; e.pc_sel = 1; e.cyc = 4 + wi; end
         OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM: begin e.wen = 1; e.cyc = 4 + wi; end
         OPC_SYSTEM: e.halt = 1;
         default:    begin e.halt = 1; e.err = 1; end
      endcase
      if (!e.halt) model_instret = model_instret + 32'd1;
      e.instret = model_instret;
      exp_q.push_back(e);
      while (!done && guard < 64) begin
         @(negedge clk);
         guard++;
         start        = 0;
         branch_taken = bt;
         if (imem_req) begin
            if (wic == 0) begin
               imem_ready = 1;
               opcode     = op;
            end else begin
               imem_ready = 0;
               wic--;
            end
         end else begin
            imem_ready = 1'($urandom_range(0, 1));
         end
         if (dmem_req) begin
            if (wdc == 0) dmem_ready = 1;
            else begin
               dmem_ready = 0;
               wdc--;
            end
         end else begin
            dmem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         if (pc_write || halted) done = 1;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL instr_timeout: opcode %b still pending after %0d cycles", op, guard);
      end
   endtask

   initial begin : stimulus
      logic [6:0] legal [9];
      int         n;
      int         guard;
      bit         got;
      legal = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
                OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM};
      reset = 1; start = 0; opcode = 7'd0; branch_taken = 0; imem_ready = 0; dmem_ready = 0;
      reset2 = 1; start2 = 0; opcode2 = 7'd0; branch_taken2 = 0; imem_ready2 = 0; dmem_ready2 = 0;

      do_reset();
      #1;
      check("reset_state", state, 0);
      check("reset_halted", halted, 0);
      check("reset_error", error, 0);
      check("reset_instret", instret, 0);
      check("reset_imem_req", imem_req, 0);
      check("reset_pc_write", pc_write, 0);

      // Directed: ADDI, taken/not-taken BEQ, LW with delayed ready, SW
      start_run();
      run_instr(OPC_OPIMM, 0, 0, 0);
      run_instr(OPC_BRANCH, 0, 0, 1);
      run_instr(OPC_BRANCH, 0, 0, 0);
      run_instr(OPC_LOAD, 0, 3, 0);
      run_instr(OPC_STORE, 0, 0, 0);
      for (int i = 0; i < 150; i++)
         run_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      run_instr(OPC_SYSTEM, $urandom_range(0, 2), 0, 0);

      // Halt is sticky against start
      repeat (3) begin
         @(negedge clk); start = 1;
         @(negedge clk); start = 0;
      end
      #1;
      check("halt_sticky_state", state, 6);
      check("halt_sticky_halted", halted, 1);
      check("halt_sticky_imem_req", imem_req, 0);

      do_reset();
      start_run();
      run_instr(7'b1111111, 1, 0, 0);

      // Reset while a load waits on dmem, with dmem_ready in the reset cycle
      do_reset();
      start_run();
      run_instr(OPC_OPIMM, 0, 0, 0);
      n = 0; guard = 0;
      while (n < 3 && guard < 32) begin
         @(negedge clk);
         guard++;
         dmem_ready = 0;
         imem_ready = imem_req;
         if (imem_req) opcode = OPC_LOAD;
         #1;
         if (dmem_req) n++;
      end
      check("midreset_reached_mem_wait", n, 3);
      @(negedge clk);
      reset = 1; dmem_ready = 1; imem_ready = 0;
      #1;
      check("midreset_reset_cycle_no_wenb", reg_wenb, 0);
      @(negedge clk);
      reset = 0; dmem_ready = 0; model_instret = 0;
      #1;
      check("midreset_state", state, 0);
      check("midreset_dmem_req", dmem_req, 0);
      check("midreset_instret", instret, 0);
      check("midreset_reg_wenb", reg_wenb, 0);

      // Short-timeout instance: fetch never answered
      repeat (2) @(negedge clk);
      reset2 = 0; start2 = 1;
      n = 0; guard = 0; got = 0;
      while (!got && guard < 20) begin
         @(negedge clk);
         guard++;
         start2 = 0;
         #1;
         if (halted2) got = 1;
         else if (imem_req2) n++;
      end
      check("fetch_timeout_req_cycles", n, 4);
      check("fetch_timeout_halted", halted2, 1);
      check("fetch_timeout_error", error2, 1);
      check("fetch_timeout_state", state2, 6);
      @(negedge clk); start2 = 1;
      @(negedge clk); start2 = 0;
      #1;
      check("timeout_halt_ignores_start", state2, 6);
      check("timeout_halt_no_req", imem_req2, 0);

      // Ready on the expiring cycle wins; then a load whose dmem never answers
      @(negedge clk); reset2 = 1;
      repeat (2) @(negedge clk);
      reset2 = 0; start2 = 1;
      n = 0; got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         start2 = 0; imem_ready2 = 0;
         if (imem_req2) begin
            n++;
            if (n == 4) begin
               imem_ready2 = 1;
               opcode2     = OPC_LOAD;
            end
         end
         #1;
         if (ir_load2) got = 1;
      end
      check("ready_at_limit_ir_load", got, 1);
      @(negedge clk);
      imem_ready2 = 0;
      #1;
      check("ready_at_limit_not_halted", halted2, 0);
      check("ready_at_limit_decode", state2, 2);
      n = 0; guard = 0; got = 0;
      while (!got && guard < 20) begin
         @(negedge clk);
         guard++;
         #1;
         if (halted2) got = 1;
         else if (dmem_req2) begin
            n++;
            check("mem_timeout_load_we", dmem_we2, 0);
         end
      end
      check("mem_timeout_req_cycles", n, 4);
      check("mem_timeout_error", error2, 1);
      check("mem_timeout_instret", instret2, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
